// File: rtl/trace_cmd_pkg.sv
// trace_cmd_pkg: shared constants and types for the trace host command sequencer.
//   - framing bytes (SYNC, ACK, NAK)
//   - opcodes
//   - trace width encodings
//   - FSM state enum
//   - widthArgOk(): legal SET_WIDTH argument check
package trace_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    localparam logic [7:0] OP_SET_WIDTH   = 8'h01;
    localparam logic [7:0] OP_ENABLE      = 8'h02;
    localparam logic [7:0] OP_CLEAR_STATS = 8'h03;
    localparam logic [7:0] OP_FLUSH       = 8'h04;

    localparam logic [1:0] WIDTH_1 = 2'b01;
    localparam logic [1:0] WIDTH_2 = 2'b10;
    localparam logic [1:0] WIDTH_4 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_ARG,
        ST_CHK,
        ST_EXEC,
        ST_QUIESCE,
        ST_FLUSH,
        ST_RESP
    } state_t;

    // Only the three defined width codes are legal; any upper bit set is a bad argument.
    function automatic logic widthArgOk(input logic [7:0] a);
        return (a[7:2] == 6'd0) && (a[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/trace_cmd_ctrl_if.sv
// trace_cmd_ctrl_if: host transport byte channel.
//   RxedEvent/DataIn : received byte strobe + data (transport -> controller)
//   RspData/RspValid : response byte (controller -> transport)
//   RspReady         : transport accepts the response byte
// master = transport side, slave = command controller side.
interface trace_cmd_ctrl_if;
    logic       RxedEvent;
    logic [7:0] DataIn;
    logic [7:0] RspData;
    logic       RspValid;
    logic       RspReady;

    modport master (
        output RxedEvent, DataIn, RspReady,
        input  RspData, RspValid
    );

    modport slave (
        input  RxedEvent, DataIn, RspReady,
        output RspData, RspValid
    );
endinterface

// File: rtl/trace_cmd_ctrl_cmd_timer.sv
// cmd_timer: loadable down-counter that stops at zero.
//   clk, rst   : clock, async active-low reset
//   load       : load loadVal (wins over counting)
//   loadVal    : reload value
//   cnt        : current count
//   expired    : cnt == 0
// Loading L on edge e makes expired visible to the FSM on edge e+L+1.
module cmd_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    output logic [W-1:0] cnt,
    output logic         expired
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                cnt <= '0;
        else if (load)           cnt <= loadVal;
        else if (cnt != '0)      cnt <= cnt - W'(1);
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/trace_cmd_ctrl.sv
// trace_cmd_ctrl: host command sequencer for the trace capture path.
// Parses SYNC/OPC/ARG/CHK frames and drives the trace front end configuration,
// answering each frame with ACK or NAK.
//   clk, rst  : clock, async active-low reset
//   host      : byte channel (receive strobe/data, response handshake)
//   Width     : trace port width code (reset 11)
//   TraceEn   : capture enable
//   StatsClr  : one-cycle statistics clear pulse
//   FlushReq  : frame-buffer flush request (level), FlushAck completes it
//   Busy      : FSM not in IDLE
//   ErrCnt    : saturating protocol error count
module trace_cmd_ctrl
    import trace_cmd_pkg::*;
#(
    parameter int TIMEOUT      = 1_920_000,
    parameter int QUIET_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    trace_cmd_ctrl_if.slave        host,
    output logic [1:0]             Width,
    output logic                   TraceEn,
    output logic                   StatsClr,
    output logic                   FlushReq,
    input  logic                   FlushAck,
    output logic                   Busy,
    output logic [7:0]             ErrCnt
);
    localparam int TW = $clog2(TIMEOUT);

    state_t        state, stateNext;
    logic [7:0]    opcReg, opcNext, argReg, argNext;
    logic          savedEn, savedEnNext;
    logic [1:0]    widthNext;
    logic          traceEnNext, statsClrNext, flushReqNext;
    logic [7:0]    rspData, rspDataNext;
    logic          rspValid, rspValidNext;
    logic          errInc, sendRsp;
    logic [7:0]    rspByte;
    logic          tmrLoad, tmrExp;
    logic [TW-1:0] tmrVal, tmrCnt;
    logic          widthOk, widthChange, applyWidth;

    assign host.RspData  = rspData;
    assign host.RspValid = rspValid;

    assign widthOk     = widthArgOk(argReg);
    assign widthChange = widthOk && (argReg[1:0] != Width);

    // One timer serves inter-byte timeout, QUIESCE count and flush timeout.
    cmd_timer #(.W(TW)) uTimer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmrLoad),
        .loadVal (tmrVal),
        .cnt     (tmrCnt),
        .expired (tmrExp)
    );

    always_comb begin
        stateNext    = state;
        opcNext      = opcReg;
        argNext      = argReg;
        savedEnNext  = savedEn;
        widthNext    = Width;
        traceEnNext  = TraceEn;
        statsClrNext = 1'b0;
        flushReqNext = FlushReq;
        rspValidNext = rspValid;
        rspDataNext  = rspData;
        errInc       = 1'b0;
        sendRsp      = 1'b0;
        rspByte      = ACK_BYTE;
        tmrLoad      = 1'b0;
        tmrVal       = TW'(TIMEOUT - 1);
        applyWidth   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (host.RxedEvent && host.DataIn == SYNC_BYTE) begin
                    stateNext = ST_OPC;
                    tmrLoad   = 1'b1;
                end
            end
            // A byte on the expiry edge takes priority over the timeout.
            ST_OPC: begin
                if (host.RxedEvent) begin
                    opcNext   = host.DataIn;
                    stateNext = ST_ARG;
                    tmrLoad   = 1'b1;
                end else if (tmrExp) begin
                    stateNext = ST_IDLE;
                    errInc    = 1'b1;
                end
            end
            ST_ARG: begin
                if (host.RxedEvent) begin
                    argNext   = host.DataIn;
                    stateNext = ST_CHK;
                    tmrLoad   = 1'b1;
                end else if (tmrExp) begin
                    stateNext = ST_IDLE;
                    errInc    = 1'b1;
                end
            end
            // Immediate side effects are applied on the CHK edge so they are
            // visible in the EXEC cycle; EXEC then produces the response.
            ST_CHK: begin
                if (host.RxedEvent) begin
                    if (host.DataIn == (opcReg ^ argReg)) begin
                        stateNext = ST_EXEC;
                        case (opcReg)
                            OP_ENABLE:      traceEnNext  = argReg[0];
                            OP_CLEAR_STATS: statsClrNext = 1'b1;
                            OP_SET_WIDTH: begin
                                if (widthChange) begin
                                    savedEnNext = TraceEn;
                                    traceEnNext = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        sendRsp = 1'b1;
                        rspByte = NAK_BYTE;
                        errInc  = 1'b1;
                    end
                end else if (tmrExp) begin
                    stateNext = ST_IDLE;
                    errInc    = 1'b1;
                end
            end
            ST_EXEC: begin
                if (host.RxedEvent) errInc = 1'b1;
                case (opcReg)
                    OP_SET_WIDTH: begin
                        if (!widthOk) begin
                            sendRsp = 1'b1;
                            rspByte = NAK_BYTE;
                            errInc  = 1'b1;
                        end else if (!widthChange) begin
                            sendRsp = 1'b1;
                        end else begin
                            // Width lands on the QUIET_CYCLES-th edge after CHK;
                            // with a single quiet cycle that is this edge.
                            stateNext  = ST_QUIESCE;
                            tmrLoad    = 1'b1;
                            tmrVal     = TW'(QUIET_CYCLES - 1);
                            applyWidth = (QUIET_CYCLES == 1);
                        end
                    end
                    OP_ENABLE, OP_CLEAR_STATS: sendRsp = 1'b1;
                    OP_FLUSH: begin
                        flushReqNext = 1'b1;
                        stateNext    = ST_FLUSH;
                        tmrLoad      = 1'b1;
                    end
                    default: begin
                        sendRsp = 1'b1;
                        rspByte = NAK_BYTE;
                        errInc  = 1'b1;
                    end
                endcase
            end
            // Apply at count 1, acknowledge one edge later at count 0.
            ST_QUIESCE: begin
                if (host.RxedEvent) errInc = 1'b1;
                if (tmrCnt == TW'(1)) applyWidth = 1'b1;
                if (tmrExp) sendRsp = 1'b1;
            end
            ST_FLUSH: begin
                if (host.RxedEvent) errInc = 1'b1;
                if (FlushAck) begin
                    flushReqNext = 1'b0;
                    sendRsp      = 1'b1;
                end else if (tmrExp) begin
                    flushReqNext = 1'b0;
                    sendRsp      = 1'b1;
                    rspByte      = NAK_BYTE;
                    errInc       = 1'b1;
                end
            end
            ST_RESP: begin
                if (host.RxedEvent) errInc = 1'b1;
                if (rspValid && host.RspReady) begin
                    rspValidNext = 1'b0;
                    stateNext    = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase

        if (applyWidth) begin
            widthNext   = argReg[1:0];
            traceEnNext = savedEn;
        end

        if (sendRsp) begin
            stateNext    = ST_RESP;
            rspValidNext = 1'b1;
            rspDataNext  = rspByte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            opcReg   <= 8'h00;
            argReg   <= 8'h00;
            savedEn  <= 1'b0;
            Width    <= WIDTH_4;
            TraceEn  <= 1'b0;
            StatsClr <= 1'b0;
            FlushReq <= 1'b0;
            rspValid <= 1'b0;
            rspData  <= 8'h00;
            Busy     <= 1'b0;
            ErrCnt   <= 8'h00;
        end else begin
            state    <= stateNext;
            opcReg   <= opcNext;
            argReg   <= argNext;
            savedEn  <= savedEnNext;
            Width    <= widthNext;
            TraceEn  <= traceEnNext;
            StatsClr <= statsClrNext;
            FlushReq <= flushReqNext;
            rspValid <= rspValidNext;
            rspData  <= rspDataNext;
            Busy     <= (stateNext != ST_IDLE);
            if (errInc && ErrCnt != 8'hFF) ErrCnt <= ErrCnt + 8'd1;
        end
    end
endmodule

// File: doc/trace_cmd_ctrl.md
# trace_cmd_ctrl

Host command sequencer for the trace capture path. Parses a framed byte stream from the host transport (UART or SPI receive side) and sequences configuration of the trace front end: port width, capture enable, statistics clear and frame-buffer flush. Each command is answered with a one-byte ACK/NAK. Width changes are applied only after a quiet period with capture disabled, so the trace interface never sees a width change while it is sampling.

## Interface
- TIMEOUT, 1_920_000: inter-byte and flush-ack timeout in clk cycles (10 ms at 192 MHz); ≥2.
- QUIET_CYCLES, 16: cycles TraceEn is held low before a width change is applied; ≥1.
- clk  in  1  system clock (192 MHz PLL output).
- rst  in  1  reset; **asynchronous, active-low** (asserted when 0).
- RxedEvent  in  1  one-cycle strobe: DataIn holds a received byte.
- DataIn  in  8  received byte.
- RspData  out  8  response byte; reset 0x00.
- RspValid  out  1  response byte valid; reset 0.
- RspReady  in  1  transport accepts RspData.
- Width  out  2  trace width: 01=1 bit, 10=2 bit, 11=4 bit (00 never driven); reset 11.
- TraceEn  out  1  capture enable; reset 0.
- StatsClr  out  1  one-cycle pulse to clear frame statistics; reset 0.
- FlushReq  out  1  frame-buffer flush request, level; reset 0.
- FlushAck  in  1  flush complete.
- Busy  out  1  high in any state other than IDLE; reset 0.
- ErrCnt  out  8  saturating protocol error count; reset 0.

## Operation
- Frame layout: SYNC (0xA5), OPC, ARG, CHK. CHK must equal OPC^ARG.
- Response byte: ACK = 0x06, NAK = 0x15.
- States: IDLE, OPC, ARG, CHK, EXEC, QUIESCE, FLUSH, RESP.
- IDLE: on 0xA5, go to OPC. Any other byte is ignored and is not counted as an error.
- OPC / ARG / CHK: each accepted byte is latched and the FSM advances. A correct CHK goes to EXEC. A wrong CHK sends NAK via RESP and increments ErrCnt.
- Opcodes:
  - 0x01 SET_WIDTH. ARG must be in {01,10,11}. If ARG equals the current Width, send ACK immediately. Otherwise save TraceEn, drive TraceEn=0, and go to QUIESCE.
  - 0x02 ENABLE. TraceEn<=ARG[0]; send ACK.
  - 0x03 CLEAR_STATS. Pulse StatsClr for one cycle; send ACK.
  - 0x04 FLUSH. Drive FlushReq=1 and go to FLUSH.
  - Unknown opcode, or bad SET_WIDTH argument: send NAK and increment ErrCnt.
- QUIESCE: count QUIET_CYCLES. On the final cycle, update Width and restore the saved TraceEn, then send ACK.
- FLUSH: hold FlushReq until FlushAck=1 is sampled, then drop FlushReq and send ACK. If TIMEOUT cycles pass without FlushAck, drop FlushReq, send NAK and increment ErrCnt.
- RESP: hold RspValid=1 with RspData stable until RspValid&&RspReady, then go to IDLE.
- Bytes arriving in EXEC, QUIESCE, FLUSH or RESP are dropped and increment ErrCnt.
- Inter-byte timeout: the timer reloads on every accepted byte in OPC, ARG or CHK. On expiry, return silently to IDLE with no response and increment ErrCnt.
- ErrCnt saturates at 255.

## Timing
- Outputs are registered. The FSM advances on the clk edge that samples RxedEvent=1.
- CHK sampled at edge n: EXEC at n+1.
  - StatsClr is high in cycle n+1 to n+2.
  - TraceEn (ENABLE) changes at n+1.
  - RspValid rises at n+2 for immediate ACK/NAK.
- Wrong CHK: RspValid rises at n+1 (EXEC is skipped).
- SET_WIDTH with a change: TraceEn falls at n+1. Width changes and TraceEn is restored at n+1+QUIET_CYCLES. RspValid rises one cycle later.
- FlushAck sampled at edge m: FlushReq low at m+1, RspValid at m+1.
- Timeout expiring on the same edge a byte arrives: the byte wins and the timer reloads.
- An error increment coinciding with saturation stays at 255.
- Asynchronous reset at any point:
  - All outputs return to reset values immediately, including dropping an in-flight FlushReq or RspValid.
  - The FSM returns to IDLE.
  - The first edge after release is a normal IDLE cycle.

## Structure
- Package trace_cmd_pkg holds:
  - SYNC, ACK and NAK byte constants.
  - Opcode constants.
  - Width encodings.
  - The FSM state enum.
- Sub-module cmd_timer: one down-counter with load/expire, width $clog2(TIMEOUT). It is shared by the inter-byte timeout, the flush timeout and the QUIESCE count, since these never overlap.

## Test plan
- Reset, then A5 02 01 03 with RspReady=1 → TraceEn=1 at n+1, RspData=0x06 pulse at n+2, Busy low afterwards.
- TraceEn=1, Width=11, send A5 01 02 03 (QUIET_CYCLES=16) → TraceEn low for 16 cycles, Width=10 with TraceEn=1 again, then ACK.
- A5 03 00 00 (bad CHK) → NAK 0x15, ErrCnt=1, StatsClr never pulses; then A5 03 00 03 → exactly one StatsClr pulse, then ACK.
- A5 04 00 04 with FlushAck stuck low (TIMEOUT=100) → FlushReq high for 100 cycles, then NAK, ErrCnt increments; repeat with FlushAck at cycle 5 → ACK.
- A5 01, then silence ≥TIMEOUT → return to IDLE, no RspValid, ErrCnt+1; also a byte arriving on the expiry edge → accepted.
- Mid-QUIESCE async reset → TraceEn=0, Width=11 immediately; hold RspReady=0 in RESP → RspValid/RspData stable; 300 errors → ErrCnt=255.
